mem_port_arbiter: RTL

Two-requester arbiter and sequencer for the 8×8 single-port RAM (`b64_memory`). It accepts read/write transactions from two independent masters over valid/ready handshakes and grants them round-robin. It drives the RAM's `we`/`addr`/`wrdata`/`rst` pins from registers and returns read data or write acknowledges to the granted master. It also runs whole-array clear requests, which have priority over normal traffic.

---
 rtl/mem_ctrl_pkg.sv | 16 +
 rtl/rr_arb2.sv | 31 +++
 rtl/mem_port_arbiter.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the single-port RAM controllers.
// Holds the sequencer state encoding, the requester count and the default RAM geometry.
package mem_ctrl_pkg;

   localparam int N_REQ          = 2;
   localparam int DEF_ADDR_WIDTH = 3;
   localparam int DEF_DATA_WIDTH = 8;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ISSUE   = 2'd1,
      ST_CAPTURE = 2'd2,
      ST_CLEAR   = 2'd3
   } state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: a lone requester wins outright, and on a conflict
// the requester that did not win last time is granted.
module rr_arb2
   import mem_ctrl_pkg::*;
(
   input  logic             en,
   input  logic [N_REQ-1:0] req_valid,
   input  logic             last_grant,
   output logic [N_REQ-1:0] grant,
   output logic             grant_id,
   output logic             upd
);

   always_comb begin
      grant_id = 1'b0;
      grant    = '0;
      upd      = 1'b0;
      unique case (req_valid)
         2'b01:   grant_id = 1'b0;
         2'b10:   grant_id = 1'b1;
         2'b11:   grant_id = ~last_grant;
         default: grant_id = 1'b0;
      endcase
      // With a grant the handshake is guaranteed, so the strobe doubles as accept.
      if (en && (req_valid != '0)) begin
         upd             = 1'b1;
         grant[grant_id] = 1'b1;
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates two valid/ready masters onto one single-port RAM, one transaction
// at a time, and runs whole-array clears ahead of normal traffic.
module mem_port_arbiter
   import mem_ctrl_pkg::*;
#(
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int DATA_WIDTH = DEF_DATA_WIDTH
)
(
   input  logic                  clk,
   input  logic                  rst,
   // Handshake: a request is accepted on a rising edge where req_valid[i] & req_ready[i].
   input  logic [N_REQ-1:0]      req_valid,
   output logic [N_REQ-1:0]      req_ready,
   input  logic [N_REQ-1:0]      req_we,
   input  logic [ADDR_WIDTH-1:0] req_addr0,
   input  logic [ADDR_WIDTH-1:0] req_addr1,
   input  logic [DATA_WIDTH-1:0] req_wdata0,
   input  logic [DATA_WIDTH-1:0] req_wdata1,
   output logic [N_REQ-1:0]      rsp_valid,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   input  logic                  clr_req,
   output logic                  clr_done,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wrdata,
   output logic                  mem_rst,
   input  logic [DATA_WIDTH-1:0] mem_rddata,
   output state_e                dbg_state
);

   state_e                  state_q, state_d;
   logic                    last_grant_q, last_grant_d;
   logic                    owner_q, owner_d;
   logic                    mem_we_q, mem_we_d;
   logic                    mem_rst_q, mem_rst_d;
   logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
   logic [DATA_WIDTH-1:0]   mem_wrdata_q, mem_wrdata_d;
   logic [N_REQ-1:0]        rsp_valid_q, rsp_valid_d;
   logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
   logic                    clr_done_q, clr_done_d;

   logic                    arb_en;
   logic [N_REQ-1:0]        arb_grant;
   logic                    arb_id;
   logic                    arb_upd;

   // A pending clear blocks every grant in the IDLE cycle it is seen.
   assign arb_en = (state_q == ST_IDLE) && !clr_req;

   rr_arb2 u_arb (
      .en         (arb_en),
      .req_valid  (req_valid),
      .last_grant (last_grant_q),
      .grant      (arb_grant),
      .grant_id   (arb_id),
      .upd        (arb_upd)
   );

   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      owner_d      = owner_q;
      mem_we_d     = mem_we_q;
      mem_rst_d    = 1'b0;
      mem_addr_d   = mem_addr_q;
      mem_wrdata_d = mem_wrdata_q;
      rsp_valid_d  = '0;
      rsp_rdata_d  = rsp_rdata_q;
      clr_done_d   = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (clr_req) begin
               mem_rst_d = 1'b1;
               mem_we_d  = 1'b0;
               state_d   = ST_CLEAR;
            end else if (arb_upd) begin
               mem_addr_d   = arb_id ? req_addr1 : req_addr0;
               mem_we_d     = req_we[arb_id];
               mem_wrdata_d = req_we[arb_id] ? (arb_id ? req_wdata1 : req_wdata0) : '0;
               owner_d      = arb_id;
               last_grant_d = arb_id;
               state_d      = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            // The RAM samples the pins on the edge leaving this state.
            if (mem_we_q) begin
               mem_we_d             = 1'b0;
               rsp_valid_d[owner_q] = 1'b1;
               rsp_rdata_d          = '0;
               state_d              = ST_IDLE;
            end else begin
               state_d = ST_CAPTURE;
            end
         end
         ST_CAPTURE: begin
            rsp_rdata_d          = mem_rddata;
            rsp_valid_d[owner_q] = 1'b1;
            state_d              = ST_IDLE;
         end
         ST_CLEAR: begin
            clr_done_d = 1'b1;
            state_d    = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         last_grant_q <= 1'b1;
         owner_q      <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_rst_q    <= 1'b0;
         mem_addr_q   <= '0;
         mem_wrdata_q <= '0;
         rsp_valid_q  <= '0;
         rsp_rdata_q  <= '0;
         clr_done_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         owner_q      <= owner_d;
         mem_we_q     <= mem_we_d;
         mem_rst_q    <= mem_rst_d;
         mem_addr_q   <= mem_addr_d;
         mem_wrdata_q <= mem_wrdata_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_rdata_q  <= rsp_rdata_d;
         clr_done_q   <= clr_done_d;
      end
   end

   assign req_ready  = arb_grant;
   assign rsp_valid  = rsp_valid_q;
   assign rsp_rdata  = rsp_rdata_q;
   assign clr_done   = clr_done_q;
   assign mem_we     = mem_we_q;
   assign mem_addr   = mem_addr_q;
   assign mem_wrdata = mem_wrdata_q;
   assign mem_rst    = mem_rst_q;
   assign dbg_state  = state_q;

endmodule
